// File: rtl/anti_rebote_pkg.sv
// Shared constants for the push-button debouncer.
package anti_rebote_pkg;

  // 50 us at 100 MHz; real boards usually want about 5 ms.
  localparam int unsigned DEFAULT_STABLE_CYCLES = 5000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, synchronous reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/anti_rebote.sv
// Push-button debouncer: btn_out follows the synchronized button level only
// after that level has differed from btn_out for STABLE_CYCLES consecutive cycles.
module anti_rebote
  import anti_rebote_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] counter_next;
  logic             btn_next;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (sync1)
  );

  // Any sample matching btn_out restarts the stability window.
  always_comb begin
    counter_next = '0;
    btn_next     = btn_out;
    if (sync1 != btn_out) begin
      if (counter == CNT_LAST) begin
        btn_next = sync1;
      end else begin
        counter_next = counter + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= '0;
      btn_out <= 1'b0;
    end else begin
      counter <= counter_next;
      btn_out <= btn_next;
    end
  end

endmodule

// File: tb/tb_anti_rebote.sv
// Directed bench for anti_rebote at STABLE_CYCLES=5000 and STABLE_CYCLES=1.
module tb_anti_rebote;

  localparam int unsigned S = 5000;

  logic clk;
  logic rst;
  logic btn_in;
  logic btn_out;
  logic btn_in1;
  logic btn_out1;

  int checks   = 0;
  int failures = 0;

  anti_rebote #(.STABLE_CYCLES(S)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .btn_in  (btn_in),
    .btn_out (btn_out)
  );

  anti_rebote #(.STABLE_CYCLES(1)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .btn_in  (btn_in1),
    .btn_out (btn_out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; inputs are driven and outputs sampled 1 ns later.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Run n cycles and require btn_out to equal exp on every one of them.
  task automatic hold(input int n, input logic exp, input string tag);
    logic bad;
    bad = 1'b0;
    repeat (n) begin
      tick();
      if (btn_out !== exp) bad = 1'b1;
    end
    chk(tag, bad, 1'b0);
  endtask

  // Bounce around final_lvl in 100-cycle steps, then settle on final_lvl.
  task automatic bounce(input logic final_lvl, input string tag);
    logic old_lvl;
    old_lvl = ~final_lvl;
    for (int i = 0; i < 6; i++) begin
      btn_in = (i % 2 == 0) ? final_lvl : old_lvl;
      hold(100, old_lvl, {tag, "_during_bounce"});
    end
    btn_in = final_lvl;
    hold(S + 1, old_lvl, {tag, "_before_edge"});
    tick();
    chk({tag, "_edge"}, btn_out, final_lvl);
    hold(10000 - S - 2, final_lvl, {tag, "_stable"});
  endtask

  initial begin
    rst     = 1'b1;
    btn_in  = 1'b1;
    btn_in1 = 1'b0;

    // Reset with the button held high
    tick();
    chk("reset_cycle0", btn_out, 1'b0);
    tick();
    chk("reset_cycle1", btn_out, 1'b0);
    chk("reset_dut1", btn_out1, 1'b0);
    rst = 1'b0;
    hold(S + 1, 1'b0, "after_reset_low");
    tick();
    chk("after_reset_rise", btn_out, 1'b1);

    // Return to 0 through reset, then bouncing rise and fall
    btn_in = 1'b0;
    rst    = 1'b1;
    tick(2);
    chk("reset_again", btn_out, 1'b0);
    rst = 1'b0;
    tick(5);
    bounce(1'b1, "rise");
    bounce(1'b0, "fall");

    // Glitch one cycle short of the window
    btn_in = 1'b1;
    tick(S - 1);
    btn_in = 1'b0;
    hold(20, 1'b0, "glitch_short");

    // Pulse long enough to pass, then a clean fall
    btn_in = 1'b1;
    hold(S + 1, 1'b0, "pulse_long_before");
    tick();
    chk("pulse_long_rise", btn_out, 1'b1);
    tick();
    btn_in = 1'b0;
    hold(S + 1, 1'b1, "clean_fall_before");
    tick();
    chk("clean_fall_edge", btn_out, 1'b0);

    // Reset mid-count discards progress
    btn_in = 1'b1;
    tick(3000);
    chk("midcount_pre_reset", btn_out, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hold(S + 1, 1'b0, "midcount_after_reset");
    tick();
    chk("midcount_rise", btn_out, 1'b1);

    // STABLE_CYCLES=1: clean change lands three edges later
    btn_in1 = 1'b1;
    tick(2);
    chk("s1_rise_before", btn_out1, 1'b0);
    tick();
    chk("s1_rise", btn_out1, 1'b1);
    btn_in1 = 1'b0;
    tick(2);
    chk("s1_fall_before", btn_out1, 1'b1);
    tick();
    chk("s1_fall", btn_out1, 1'b0);

    // STABLE_CYCLES=1: single-cycle pulse passes through as a single-cycle pulse
    btn_in1 = 1'b1;
    tick();
    btn_in1 = 1'b0;
    tick();
    chk("s1_pulse_pre", btn_out1, 1'b0);
    tick();
    chk("s1_pulse_high", btn_out1, 1'b1);
    tick();
    chk("s1_pulse_low", btn_out1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
